// File: rtl/pipeline_hazard_scoreboard_if.sv
// Decode-side request and stage-control bundle for pipeline_hazard_scoreboard.
// The flush wire exists only when PIPE_HAZ_FLUSH_EN is defined.
interface pipeline_hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 16
);
    logic                   dec_valid;
    logic [REG_AW-1:0]      rs1_dec;
    logic [REG_AW-1:0]      rs2_dec;
    logic                   rs1_used_dec;
    logic                   rs2_used_dec;
    logic [REG_AW-1:0]      rd_dec;
    logic                   rd_used_dec;
    logic [LAT_W-1:0]       lat_dec;
    logic                   ex_busy;
`ifdef PIPE_HAZ_FLUSH_EN
    logic                   flush;
`endif
    logic [5:0]             stage_ena;
    logic [5:0]             stage_nop;
    logic                   issue;
    logic [2**REG_AW-1:0]   sb_busy;
    logic [CNT_W-1:0]       stall_cnt;

    modport master (
        output dec_valid, rs1_dec, rs2_dec, rs1_used_dec, rs2_used_dec,
        output rd_dec, rd_used_dec, lat_dec, ex_busy,
`ifdef PIPE_HAZ_FLUSH_EN
        output flush,
`endif
        input  stage_ena, stage_nop, issue, sb_busy, stall_cnt
    );

    modport slave (
        input  dec_valid, rs1_dec, rs2_dec, rs1_used_dec, rs2_used_dec,
        input  rd_dec, rd_used_dec, lat_dec, ex_busy,
`ifdef PIPE_HAZ_FLUSH_EN
        input  flush,
`endif
        output stage_ena, stage_nop, issue, sb_busy, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_scoreboard.sv
// Countdown scoreboard hazard controller for the six-stage in-order core.
// Define PIPE_HAZ_FLUSH_EN to enable the branch-redirect flush mode.
module pipeline_hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int WB_LAT = 2,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    pipeline_hazard_scoreboard_if.slave bus
);
    localparam int NREG = 2**REG_AW;
    localparam int CW   = $clog2(WB_LAT + 2**LAT_W);

    typedef enum logic [1:0] {RUN, HAZARD, BUSY, FLUSH} mode_t;

    logic [NREG-1:0][CW-1:0] cnt;
    logic [CNT_W-1:0]        stall_q;
    mode_t                   mode;
    logic                    raw, waw, hazard;
    logic                    count_down, stall_inc, load;
    logic [CW-1:0]           load_val;

    // cnt[0] is held at zero, so the x0 guards only document intent
    always_comb begin
        raw = bus.dec_valid &&
              ((bus.rs1_used_dec && bus.rs1_dec != '0 && cnt[bus.rs1_dec] != '0) ||
               (bus.rs2_used_dec && bus.rs2_dec != '0 && cnt[bus.rs2_dec] != '0));
        waw = bus.dec_valid && bus.rd_used_dec && bus.rd_dec != '0 &&
              cnt[bus.rd_dec] != '0;
        hazard = raw || waw;
    end

    always_comb begin
        mode = RUN;
        if (bus.ex_busy)
            mode = BUSY;
`ifdef PIPE_HAZ_FLUSH_EN
        else if (bus.flush)
            mode = FLUSH;
`endif
        else if (hazard)
            mode = HAZARD;
    end

    always_comb begin
        bus.stage_ena = 6'b111111;
        bus.stage_nop = 6'b000000;
        bus.issue     = 1'b0;
        count_down    = 1'b1;
        stall_inc     = 1'b0;
        if (rst) begin
            bus.stage_nop = 6'b111111;
        end else begin
            case (mode)
                BUSY: begin
                    bus.stage_ena = 6'b110000;
                    bus.stage_nop = 6'b001000;
                    count_down    = 1'b0;
                    stall_inc     = 1'b1;
                end
                FLUSH: bus.stage_nop = 6'b000111;
                HAZARD: begin
                    bus.stage_ena = 6'b111100;
                    bus.stage_nop = 6'b000010;
                    stall_inc     = 1'b1;
                end
                default: bus.issue = bus.dec_valid;
            endcase
        end
    end

    assign load     = bus.issue && bus.rd_used_dec && bus.rd_dec != '0;
    assign load_val = CW'(WB_LAT) + CW'(bus.lat_dec);

    // A fresh load wins over the decrement of the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            stall_q <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (load && bus.rd_dec == REG_AW'(r))
                    cnt[r] <= load_val;
                else if (count_down && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
            if (stall_inc && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    always_comb begin
        bus.sb_busy = '0;
        for (int r = 0; r < NREG; r++)
            bus.sb_busy[r] = (cnt[r] != '0);
    end

    assign bus.stall_cnt = stall_q;
endmodule
